// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-side bus: instruction memory address/enable/data and the tagged
// instruction handed to the IF/ID register.
interface fetch_pc_ctrl_if;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_instr;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;

  modport master (
    output imem_addr, imem_en, if_instr, if_pc, if_pc4, if_valid,
    input  imem_instr
  );

  modport slave (
    input  imem_addr, imem_en, if_instr, if_pc, if_pc4, if_valid,
    output imem_instr
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: sequential/redirect/stall next-PC selection, imem drive,
// and PC tagging of returned instructions. FETCH_PERF_EN adds fetch_count.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] LAST_PC  = 32'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_pc_ctrl_if.master bus,
  output logic        misalign_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tag_pc_q, tag_pc_d;
  logic        tag_valid_q, tag_valid_d;
  logic        misalign_q, misalign_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      tag_pc_q    <= RESET_PC;
      tag_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tag_pc_q    <= tag_pc_d;
      tag_valid_q <= tag_valid_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tag_pc_d    = tag_pc_q;
    tag_valid_d = tag_valid_q;
    misalign_d  = 1'b0;
    if (redirect) begin
      // The read issued this edge is off-path; the bubble covers it.
      pc_d        = {redirect_pc[31:2], 2'b00};
      tag_valid_d = 1'b0;
      state_d     = RUN;
      misalign_d  = |redirect_pc[1:0];
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            tag_pc_d    = pc_q;
            tag_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            if (pc_q == LAST_PC) state_d = HALT;
          end
        end
        IDLE: begin
          tag_valid_d = 1'b0;
          state_d     = RUN;
        end
        default: tag_valid_d = 1'b0;
      endcase
    end
  end

  // Stall re-reads the tagged address so the registered memory output holds.
  assign bus.imem_addr = stall ? tag_pc_q : pc_q;
  assign bus.imem_en   = (state_q == RUN);
  assign bus.if_valid  = tag_valid_q;
  assign bus.if_pc     = tag_pc_q;
  assign bus.if_pc4    = tag_pc_q + 32'd4;
  assign bus.if_instr  = tag_valid_q ? bus.imem_instr : 32'h0;
  assign misalign_err  = misalign_q;

`ifdef FETCH_PERF_EN
  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (tag_valid_q && !stall) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 32'h0;
    else        count_q <= count_d;
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a 1-cycle registered instruction memory model.
module tb_fetch_pc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
`endif
  logic [31:0] mem [0:63];
  int          total = 0;
  int          passed = 0;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl #(.RESET_PC(32'h0), .LAST_PC(32'd16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Registered read, zero when disabled.
  always @(posedge clk) bus.imem_instr <= bus.imem_en ? mem[bus.imem_addr[7:2]] : 32'h0;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    logic [5:0] idx;
    idx = a[7:2];
    return (idx == 6'd0) ? 32'h0121_0003 : (32'hA000_0000 | {26'h0, idx});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'h0, bus.if_valid}, 32'd1);
    chk({tag, "_pc"}, bus.if_pc, pc);
    chk({tag, "_instr"}, bus.if_instr, instr_at(pc));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = instr_at(32'(i) << 2);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Reset state
    #12;
    chk("rst_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'h0);
    chk("rst_misalign", {31'h0, misalign_err}, 32'd0);
    chk("rst_pc", bus.if_pc, 32'h0);
    chk("rst_pc4", bus.if_pc4, 32'h4);
`ifdef FETCH_PERF_EN
    chk("rst_count", fetch_count, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("boot_en0", {31'h0, bus.imem_en}, 32'd0);

    // Boot bubble, then sequential run 0..16 and halt
    tick();
    chk("boot_en1", {31'h0, bus.imem_en}, 32'd1);
    chk("boot_bubble", {31'h0, bus.if_valid}, 32'd0);
    chk("boot_addr", bus.imem_addr, 32'h0);
    tick();
    chk_fetch("seq0", 32'h0);
    chk("seq0_instr_lit", bus.if_instr, 32'h0121_0003);
    chk("seq0_pc4", bus.if_pc4, 32'h4);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_fetch("seq", 32'(k * 4));
    end
    chk("halt_en", {31'h0, bus.imem_en}, 32'd0);
    tick();
    chk("halt_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("halt_instr", bus.if_instr, 32'h0);
    chk("halt_en2", {31'h0, bus.imem_en}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("count_run1", fetch_count, 32'd5);
`endif

    // HALT -> redirect to 8
    redirect = 1'b1; redirect_pc = 32'h8;
    tick();
    redirect = 1'b0;
    chk("hredir_en", {31'h0, bus.imem_en}, 32'd1);
    chk("hredir_bubble", {31'h0, bus.if_valid}, 32'd0);
    chk("hredir_mis", {31'h0, misalign_err}, 32'd0);
    chk("hredir_addr", bus.imem_addr, 32'h8);
    tick();
    chk_fetch("hredir_pc8", 32'h8);

    // Stall 3 cycles with if_pc = 8
    stall = 1'b1;
    #1;
    chk("stall_addr0", bus.imem_addr, 32'h8);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_fetch("stall", 32'h8);
      chk("stall_addr", bus.imem_addr, 32'h8);
    end
    stall = 1'b0;
    tick();
    chk_fetch("unstall", 32'hC);

    // Misaligned redirect in RUN
    redirect = 1'b1; redirect_pc = 32'h6;
    tick();
    redirect = 1'b0;
    chk("mis_pulse", {31'h0, misalign_err}, 32'd1);
    chk("mis_bubble", {31'h0, bus.if_valid}, 32'd0);
    tick();
    chk("mis_clear", {31'h0, misalign_err}, 32'd0);
    chk_fetch("mis_pc4", 32'h4);

    // Redirect beats simultaneous stall
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("rs_bubble", {31'h0, bus.if_valid}, 32'd0);
    tick();
    chk_fetch("rs_pc0", 32'h0);
    tick();
    chk_fetch("rs_pc4", 32'h4);

    // PC wrap at 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wrap_bubble", {31'h0, bus.if_valid}, 32'd0);
    tick();
    chk_fetch("wrap_top", 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.if_pc4, 32'h0);
    for (int k = 0; k <= 3; k++) begin
      tick();
      chk_fetch("wrap_seq", 32'(k * 4));
    end

    // Async reset mid-stream at if_pc = 12
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'h0, bus.if_valid}, 32'd0);
    chk("mrst_en", {31'h0, bus.imem_en}, 32'd0);
    chk("mrst_pc", bus.if_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("mrst_count", fetch_count, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_boot_bubble", {31'h0, bus.if_valid}, 32'd0);
    chk("mrst_boot_en", {31'h0, bus.imem_en}, 32'd1);
    for (int k = 0; k <= 4; k++) begin
      tick();
      chk_fetch("mrst_seq", 32'(k * 4));
    end
    tick();
    chk("mrst_halt", {31'h0, bus.if_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("count_run2", fetch_count, 32'd5);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
